intdiv_otf: RTL and testbench
=============================

INTDIV_OTF -- requirements
Module: intdiv_otf

Interface
REQ-001 SHALL have parameter N, default 16: number of quotient digits and output width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begins a new conversion.
REQ-005 SHALL have port dig  input  2  SD2 quotient digit, MSD first: 11 = -1; 00 = 0; 01 and 10 = +1.
REQ-006 SHALL have port dig_valid  input  1  dig is valid this cycle.
REQ-007 SHALL have port dig_ready  output  1  block accepts dig this cycle.
REQ-008 SHALL have port rem_neg  input  1  final partial remainder is negative; sampled with the last digit.
REQ-009 SHALL have port q  output  N  two's-complement binary quotient.
REQ-010 SHALL have port q_valid  output  1  q is complete and stable.
REQ-011 SHALL have port q_ack  input  1  consumer has taken q.
REQ-012 SHALL have port busy  output  1  high in RUN and HOLD.

Function
REQ-013 SHALL implement the states IDLE, RUN and HOLD.
REQ-014 IDLE SHALL behave as follows: dig_ready=0, q_valid=0; start=1 -> RUN, with Q cleared to 0, QM set to all ones and the digit counter cleared to 0.
REQ-015 RUN SHALL behave as follows: dig_ready=1; a digit is accepted only when dig_valid and dig_ready are both high; cycles with dig_valid=0 change no state.
REQ-016 On each accepted digit the block SHALL perform on-the-fly conversion, each register shifting left one bit:
- d=+1: Q <= {Q,1}, QM <= {Q,0}
- d=0: Q <= {Q,0}, QM <= {QM,1}
- d=-1: Q <= {QM,1}, QM <= {QM,0}
REQ-017 The invariant QM = Q - 1 (mod 2^N) SHALL hold after every accepted digit.
REQ-018 The counter SHALL increment per accepted digit; acceptance at count N-1 -> HOLD in the next cycle, with q_valid=1 and dig_ready=0.
REQ-019 Latency SHALL be: q_valid is asserted in the cycle after the Nth digit is accepted.
REQ-020 HOLD SHALL behave as follows: q and q_valid are stable until q_ack=1; q_ack=1 -> IDLE; q_valid=0 in the next cycle.
REQ-021 In HOLD, start=1 together with q_ack=1 SHALL go directly to RUN with the registers re-initialised as in REQ-014; start without q_ack is ignored.
REQ-022 start asserted in RUN SHALL be ignored; the conversion in progress continues.
REQ-023 q SHALL equal Q whenever q_valid=0; its value then carries no meaning.
REQ-024 Overflow SHALL wrap modulo 2^N; no overflow flag is produced.

Reset
REQ-025 rst=1 SHALL act immediately, independent of clk: state IDLE, Q=0, QM=all ones, counter=0, q=0, q_valid=0, dig_ready=0, busy=0.
REQ-026 Reset asserted mid-RUN or in HOLD SHALL abandon the conversion; no partial result is ever flagged valid.

Configuration
REQ-027 Macro INTDIV_OTF_CORRECT_EN defined: rem_neg is registered together with the last digit; in HOLD, q = QM if that flag is 1, else q = Q (restoring correction of the quotient).
REQ-028 Macro INTDIV_OTF_CORRECT_EN undefined: rem_neg is ignored and q = Q in HOLD.

Structure
REQ-029 Package intdiv_pkg SHALL hold:
- the SD2 encoding constants NEG1, ZERO, POS1_1, POS1_2
- the state encoding
REQ-030 Sub-module intdiv_sd2_dec SHALL decode dig into is_pos and is_neg (combinational); intdiv_otf SHALL instantiate it once.

Verification
REQ-031 With N=4 and digits +1,0,-1,+1 sent back-to-back, the bench SHALL check q=0111 and q_valid=1 exactly one cycle after the 4th digit.
REQ-032 With N=4 and digits -1,0,0,0, the bench SHALL check q=1000; with digits 0,0,0,0 it SHALL check q=0000; POS1_1 and POS1_2 SHALL give identical results.
REQ-033 With N=4, digits +1,0,-1,+1 and rem_neg=1 on the last digit, the bench SHALL check q=0110 with INTDIV_OTF_CORRECT_EN defined and q=0111 without it.
REQ-034 With dig_valid low for 3 cycles between digits 2 and 3, the bench SHALL check that the result is unchanged (0111) and that q_valid does not assert early.
REQ-035 With rst pulsed between clock edges after 2 digits, the bench SHALL check that q_valid=0, the state is IDLE and q=0 immediately, and that a following full conversion is correct.
REQ-036 In HOLD, with q_ack=1 and start=1 in the same cycle, the bench SHALL check RUN in the next cycle with dig_ready=1, and that the new digits 0,0,0,+1 give q=0001.

Source files
------------

// File: rtl/intdiv_pkg.sv
`default_nettype none
// ============================================================================
// intdiv_pkg : SD2 digit encodings and FSM state type for intdiv_otf.
// Rev 1.0
// ============================================================================
package intdiv_pkg;

    localparam logic [1:0] NEG1   = 2'b11;
    localparam logic [1:0] ZERO   = 2'b00;
    localparam logic [1:0] POS1_1 = 2'b01;
    localparam logic [1:0] POS1_2 = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/intdiv_sd2_dec.sv
`default_nettype none
// ============================================================================
// intdiv_sd2_dec : combinational decode of an SD2 digit into +1 / -1 flags.
// Rev 1.0
// ============================================================================
module intdiv_sd2_dec
    import intdiv_pkg::*;
(
    input  logic [1:0] dig,
    output logic       is_pos,
    output logic       is_neg
);

    assign is_pos = (dig == POS1_1) || (dig == POS1_2);
    assign is_neg = (dig == NEG1);

endmodule
`default_nettype wire

// File: rtl/intdiv_otf.sv
`default_nettype none
// ============================================================================
// intdiv_otf : on-the-fly SD2 -> two's-complement quotient converter.
//              Optional restoring correction via INTDIV_OTF_CORRECT_EN.
// Rev 1.0
// ============================================================================
module intdiv_otf
    import intdiv_pkg::*;
#(
    parameter int N = 16
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   dig,
    input  logic         dig_valid,
    output logic         dig_ready,
    input  logic         rem_neg,
    output logic [N-1:0] q,
    output logic         q_valid,
    input  logic         q_ack,
    output logic         busy
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_qm;
    logic [CW-1:0]   r_cnt;
    logic            w_is_pos;
    logic            w_is_neg;
    logic            w_accept;
    logic            w_last;
    logic            w_init;

    intdiv_sd2_dec u_dec (
        .dig    (dig),
        .is_pos (w_is_pos),
        .is_neg (w_is_neg)
    );

    assign w_accept = (r_state == S_RUN) && dig_valid;
    assign w_last   = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_init      = 1'b1;
                end
            end
            S_RUN: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (q_ack) begin
                    w_state_nxt = start ? S_RUN : S_IDLE;
                    w_init      = start;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // QM tracks Q-1 so a -1 digit never needs a borrow chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            r_qm  <= '1;
            r_cnt <= '0;
        end else if (w_init) begin
            r_q   <= '0;
            r_qm  <= '1;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_is_pos) begin
                r_q  <= {r_q[N-2:0], 1'b1};
                r_qm <= {r_q[N-2:0], 1'b0};
            end else if (w_is_neg) begin
                r_q  <= {r_qm[N-2:0], 1'b1};
                r_qm <= {r_qm[N-2:0], 1'b0};
            end else begin
                r_q  <= {r_q[N-2:0], 1'b0};
                r_qm <= {r_qm[N-2:0], 1'b1};
            end
        end
    end

`ifdef INTDIV_OTF_CORRECT_EN
    logic r_rem_neg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem_neg <= 1'b0;
        end else if (w_init) begin
            r_rem_neg <= 1'b0;
        end else if (w_accept && w_last) begin
            r_rem_neg <= rem_neg;
        end
    end

    assign q = ((r_state == S_HOLD) && r_rem_neg) ? r_qm : r_q;
`else
    logic w_unused_rem_neg;
    assign w_unused_rem_neg = rem_neg;
    assign q = r_q;
`endif

    assign dig_ready = (r_state == S_RUN);
    assign q_valid   = (r_state == S_HOLD);
    assign busy      = (r_state == S_RUN) || (r_state == S_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_intdiv_otf.sv
`default_nettype none
// ============================================================================
// tb_intdiv_otf : directed + randomized check of intdiv_otf (N=4).
// Rev 1.0
// ============================================================================
module tb_intdiv_otf;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   dig = 2'b00;
    logic         dig_valid = 1'b0;
    logic         dig_ready;
    logic         rem_neg = 1'b0;
    logic [N-1:0] q;
    logic         q_valid;
    logic         q_ack = 1'b0;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    intdiv_otf #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dig       (dig),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .rem_neg   (rem_neg),
        .q         (q),
        .q_valid   (q_valid),
        .q_ack     (q_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    // Reference: quotient is the weighted digit sum, minus one when corrected.
    function automatic logic [N-1:0] model(input logic [2*N-1:0] ds, input bit rn);
        int v = 0;
        logic [1:0] d;
        for (int i = 0; i < N; i++) begin
            d = ds[2*N-1-2*i -: 2];
            v = v * 2 + ((d == 2'b11) ? -1 : (d == 2'b00) ? 0 : 1);
        end
`ifdef INTDIV_OTF_CORRECT_EN
        if (rn) v = v - 1;
`else
        if (rn) v = v + 0;
`endif
        return v[N-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_ready"}, {3'b0, dig_ready}, 4'd1);
    endtask

    // Sends all digits from RUN and leaves the DUT in HOLD after checking q.
    task automatic send_all(input string tag, input logic [2*N-1:0] ds, input bit rn,
                            input int gap, input bit start_in_run);
        for (int i = 0; i < N; i++) begin
            if (i == 2) begin
                for (int g = 0; g < gap; g++) begin
                    dig_valid = 1'b0;
                    tick();
                    chk({tag, "_gap_qv"}, {3'b0, q_valid}, 4'd0);
                end
            end
            dig       = ds[2*N-1-2*i -: 2];
            dig_valid = 1'b1;
            rem_neg   = (i == N - 1) ? rn : ~rn;
            start     = start_in_run && (i == 1);
            if (i == N - 1) chk({tag, "_early_qv"}, {3'b0, q_valid}, 4'd0);
            tick();
            dig_valid = 1'b0;
            start     = 1'b0;
            rem_neg   = 1'b0;
        end
        chk({tag, "_qv"}, {3'b0, q_valid}, 4'd1);
        chk({tag, "_q"}, q, model(ds, rn));
    endtask

    task automatic do_ack(input string tag);
        q_ack = 1'b1;
        tick();
        q_ack = 1'b0;
        chk({tag, "_ack_qv"}, {3'b0, q_valid}, 4'd0);
        chk({tag, "_ack_busy"}, {3'b0, busy}, 4'd0);
    endtask

    initial begin
        logic [2*N-1:0] ds;
        logic [N-1:0]   held;
        bit             rn;

        #2;
        chk("rst_q", q, 4'd0);
        chk("rst_qv", {3'b0, q_valid}, 4'd0);
        chk("rst_ready", {3'b0, dig_ready}, 4'd0);
        chk("rst_busy", {3'b0, busy}, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // +1,0,-1,+1 -> 0111 one cycle after the 4th digit
        do_start("basic");
        send_all("basic", 8'b01_00_11_01, 1'b0, 0, 1'b0);
        chk("basic_const", q, 4'b0111);
        held = q;
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        chk("hold_stable_q", q, held);
        chk("hold_stable_qv", {3'b0, q_valid}, 4'd1);
        do_ack("basic");

        do_start("neg");
        send_all("neg", 8'b11_00_00_00, 1'b0, 0, 1'b0);
        chk("neg_const", q, 4'b1000);
        do_ack("neg");

        do_start("zero");
        send_all("zero", 8'b00_00_00_00, 1'b0, 0, 1'b0);
        chk("zero_const", q, 4'b0000);
        do_ack("zero");

        do_start("pos2");
        send_all("pos2", 8'b10_00_11_10, 1'b0, 0, 1'b0);
        chk("pos2_const", q, 4'b0111);
        do_ack("pos2");

        do_start("corr");
        send_all("corr", 8'b01_00_11_01, 1'b1, 0, 1'b0);
`ifdef INTDIV_OTF_CORRECT_EN
        chk("corr_const", q, 4'b0110);
`else
        chk("corr_const", q, 4'b0111);
`endif
        do_ack("corr");

        do_start("gap");
        send_all("gap", 8'b01_00_11_01, 1'b0, 3, 1'b0);
        chk("gap_const", q, 4'b0111);
        do_ack("gap");

        do_start("srun");
        send_all("srun", 8'b01_01_11_00, 1'b0, 0, 1'b1);
        do_ack("srun");

        // Asynchronous reset between clock edges after two digits
        do_start("mrst");
        dig = 2'b01; dig_valid = 1'b1; tick();
        dig = 2'b11; tick();
        dig_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_qv", {3'b0, q_valid}, 4'd0);
        chk("mrst_busy", {3'b0, busy}, 4'd0);
        chk("mrst_ready", {3'b0, dig_ready}, 4'd0);
        chk("mrst_q", q, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_start("post");
        send_all("post", 8'b01_00_11_01, 1'b0, 0, 1'b0);
        chk("post_const", q, 4'b0111);

        // start together with q_ack in HOLD restarts directly
        q_ack = 1'b1;
        start = 1'b1;
        tick();
        q_ack = 1'b0;
        start = 1'b0;
        chk("rs_ready", {3'b0, dig_ready}, 4'd1);
        chk("rs_qv", {3'b0, q_valid}, 4'd0);
        chk("rs_busy", {3'b0, busy}, 4'd1);
        send_all("rs", 8'b00_00_00_01, 1'b0, 0, 1'b0);
        chk("rs_const", q, 4'b0001);
        do_ack("rs");

        for (int k = 0; k < 30; k++) begin
            ds = 8'($urandom);
            rn = 1'($urandom);
            do_start("rnd");
            send_all("rnd", ds, rn, int'($urandom_range(0, 2)), 1'($urandom));
            do_ack("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
